// File: rtl/track_judge.sv
// Chicken-race referee: a player reveals cards and the chicken advances one
// tile around a fixed 16-tile track whenever the card matches the picture on
// the next tile. The game ends after LAPS completed laps.
module track_judge #(
  parameter int LAPS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pick_valid,
  input  logic [3:0] pick_card,
  output logic       ready,
  output logic       result_valid,
  output logic       go,
  output logic       win,
  output logic [3:0] pos,
  output logic [1:0] lap
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PICK,
    FETCH,
    JUDGE,
    DONE
  } state_t;

  localparam logic [1:0] LapsTarget = 2'(LAPS);

  state_t     state_q, state_d;
  logic [3:0] pos_q, pos_d;
  logic [1:0] lap_q, lap_d;
  logic       go_q, go_d;
  logic       win_q, win_d;
  logic       result_valid_q, result_valid_d;
  logic [3:0] card_q, card_d;
  logic [3:0] pic_q, pic_d;

  logic [3:0] target;
  logic [1:0] lap_inc;
  logic       match;

  // Track picture ROM: tile i shows picture (5*i) mod 12.
  function automatic logic [3:0] tile_picture(input logic [3:0] idx);
    logic [3:0] pic;
    case (idx)
      4'd0:    pic = 4'd0;
      4'd1:    pic = 4'd5;
      4'd2:    pic = 4'd10;
      4'd3:    pic = 4'd3;
      4'd4:    pic = 4'd8;
      4'd5:    pic = 4'd1;
      4'd6:    pic = 4'd6;
      4'd7:    pic = 4'd11;
      4'd8:    pic = 4'd4;
      4'd9:    pic = 4'd9;
      4'd10:   pic = 4'd2;
      4'd11:   pic = 4'd7;
      4'd12:   pic = 4'd0;
      4'd13:   pic = 4'd5;
      4'd14:   pic = 4'd10;
      default: pic = 4'd3;
    endcase
    return pic;
  endfunction

  // Next-state logic: start restarts from any state, otherwise step the pick pipeline.
  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    lap_d          = lap_q;
    go_d           = go_q;
    win_d          = win_q;
    result_valid_d = 1'b0;
    card_d         = card_q;
    pic_d          = pic_q;

    target  = pos_q + 4'd1;
    lap_inc = lap_q + 2'd1;
    match   = (card_q == pic_q) && (card_q <= 4'd11);

    if (start) begin
      state_d = WAIT_PICK;
      pos_d   = 4'd0;
      lap_d   = 2'd0;
      go_d    = 1'b0;
      win_d   = 1'b0;
    end else begin
      case (state_q)
        WAIT_PICK: begin
          if (pick_valid) begin
            card_d  = pick_card;
            state_d = FETCH;
          end
        end
        FETCH: begin
          pic_d   = tile_picture(target);
          state_d = JUDGE;
        end
        JUDGE: begin
          result_valid_d = 1'b1;
          go_d           = match;
          state_d        = WAIT_PICK;
          if (match) begin
            pos_d = target;
            if (pos_q == 4'd15) begin
              lap_d = lap_inc;
              if (lap_inc == LapsTarget) begin
                win_d   = 1'b1;
                state_d = DONE;
              end
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset to an idle, cleared game.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pos_q          <= 4'd0;
      lap_q          <= 2'd0;
      go_q           <= 1'b0;
      win_q          <= 1'b0;
      result_valid_q <= 1'b0;
      card_q         <= 4'd0;
      pic_q          <= 4'd0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      lap_q          <= lap_d;
      go_q           <= go_d;
      win_q          <= win_d;
      result_valid_q <= result_valid_d;
      card_q         <= card_d;
      pic_q          <= pic_d;
    end
  end

  assign ready        = (state_q == WAIT_PICK);
  assign result_valid = result_valid_q;
  assign go           = go_q;
  assign win          = win_q;
  assign pos          = pos_q;
  assign lap          = lap_q;

endmodule

// File: doc/track_judge.md
TRACK_JUDGE -- requirements
Module: track_judge

Interface
REQ-001 SHALL have parameter: LAPS, 2, number of completed laps that ends the game (legal 1..3).
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  single-cycle pulse that begins a new game.
REQ-005 SHALL have port: pick_valid  input  1  single-cycle pulse: player has revealed a card.
REQ-006 SHALL have port: pick_card  input  4  picture index of the revealed card; 0..11 legal, 12..15 illegal.
REQ-007 SHALL have port: ready  output  1  high when a pick will be accepted.
REQ-008 SHALL have port: result_valid  output  1  single-cycle pulse: go and win are valid for this pick.
REQ-009 SHALL have port: go  output  1  registered; 1 = pick matched, chicken advanced; 0 = miss.
REQ-010 SHALL have port: win  output  1  registered, sticky until start or rst.
REQ-011 SHALL have port: pos  output  4  current chicken tile index 0..15.
REQ-012 SHALL have port: lap  output  2  completed laps.

Function
REQ-013 SHALL implement a fixed 16-tile circular track; tile i picture = (5*i) mod 12, i.e. 0,5,10,3,8,1,6,11,4,9,2,7,0,5,10,3.
REQ-014 SHALL use states IDLE, WAIT_PICK, FETCH, JUDGE, DONE.
REQ-015 IDLE: ready=0; start -> WAIT_PICK, clearing pos=0, lap=0, win=0, go=0.
REQ-016 WAIT_PICK: ready=1; pick_valid -> latch pick_card, go to FETCH; no pick -> stay.
REQ-017 FETCH: ready=0; read picture of target tile t=(pos+1) mod 16 (4-bit wrap) into a register; -> JUDGE.
REQ-018 JUDGE: ready=0; match = (latched card == fetched picture) and latched card <= 11; result_valid=1 for exactly this cycle, with go=match updated on the same edge.
REQ-019 On match: pos<=t; if pos was 15 (wrap to 0) lap<=lap+1; if the incremented lap equals LAPS, win<=1 and -> DONE, else -> WAIT_PICK.
REQ-020 On miss: pos and lap unchanged; -> WAIT_PICK.
REQ-021 Result latency SHALL be exactly 2 cycles: pick_valid sampled at edge k -> result_valid high during the cycle after edge k+2.
REQ-022 pick_valid while ready=0 SHALL be ignored with no state change.
REQ-023 DONE: ready=0, win held 1, pos/lap frozen; start -> WAIT_PICK with the REQ-015 clears.
REQ-024 start in WAIT_PICK, FETCH or JUDGE SHALL abort the pick in flight (no result_valid) and restart as REQ-015; start has priority over pick_valid in the same cycle.
REQ-025 go SHALL hold its last value between results; lap SHALL never exceed LAPS.

Reset
REQ-026 rst SHALL force IDLE, pos=0, lap=0, go=0, win=0, ready=0, result_valid=0 on the next edge, overriding all inputs including start.
REQ-027 rst asserted mid-pick SHALL discard the pick; no result_valid after rst release until a new start and pick.

Verification
REQ-028 rst, start, pick_card=5 pulse -> 2 cycles later result_valid=1, go=1, pos=1, lap=0.
REQ-029 After start, pick_card=3 (tile 1 = 5) -> result_valid=1, go=0, pos=0.
REQ-030 Drive 16 correct picks (5,10,3,8,1,6,11,4,9,2,7,0,5,10,3,0) -> pos=0, lap=1, win=0; repeat with LAPS=2 -> win=1, state DONE, ready=0, further picks ignored.
REQ-031 pick_card=12 or 15 at any position -> go=0, pos unchanged.
REQ-032 pick_valid during FETCH, and start+pick_valid same cycle in WAIT_PICK -> first ignored; second restarts with no result_valid.
REQ-033 rst during JUDGE-bound pick -> no result_valid, all outputs zero next cycle.
